// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision FP units.
//   M, N, BIAS   : exponent width, stored mantissa width, exponent bias
//   state_t      : sequencing states of the iterative divider
//   fp_fields_t  : {sign, exp, mant} view of a packed float
//   fp_split()   : unpacks a raw word into fp_fields_t
package fp_pkg;

    localparam int unsigned M    = 8;
    localparam int unsigned N    = 23;
    localparam int unsigned BIAS = (1 << (M - 1)) - 1;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic         sign;
        logic [M-1:0] exp;
        logic [N-1:0] mant;
    } fp_fields_t;

    function automatic fp_fields_t fp_split(input logic [M+N:0] x);
        fp_fields_t f;
        f.sign = x[M+N];
        f.exp  = x[M+N-1:N];
        f.mant = x[N-1:0];
        return f;
    endfunction

endpackage

// File: rtl/fpdiv_normalize.sv
// Combinational result stage of the divider: normalises the raw quotient,
// computes the biased exponent and applies the special-case priority
// (divide-by-zero, zero dividend, overflow, underflow).
//   sign           : result sign
//   ea, eb         : biased exponents of dividend / divisor
//   q              : n+2 bit quotient, q[n+1] is the integer bit
//   zero_a, zero_b : dividend / divisor exponent was zero
//   c              : packed result {sign, exp, mant}
//   dbz, ovf, unf  : divide-by-zero, overflow, underflow flags
module fpdiv_normalize
    import fp_pkg::*;
#(
    parameter int unsigned m    = M,
    parameter int unsigned n    = N,
    parameter int unsigned BIAS = fp_pkg::BIAS
) (
    input  logic           sign,
    input  logic [m-1:0]   ea,
    input  logic [m-1:0]   eb,
    input  logic [n+1:0]   q,
    input  logic           zero_a,
    input  logic           zero_b,
    output logic [m+n:0]   c,
    output logic           dbz,
    output logic           ovf,
    output logic           unf
);

    localparam logic signed [m+1:0] BIAS_E = (m+2)'(BIAS);
    localparam logic signed [m+1:0] ONE_E  = (m+2)'(1);
    localparam logic signed [m+1:0] ZERO_E = (m+2)'(0);
    localparam logic signed [m+1:0] EMAX   = (m+2)'((1 << m) - 1);

    logic signed [m+1:0] e_base;
    logic signed [m+1:0] e;
    logic [n-1:0]        mant;

    always_comb begin
        e_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;
        // Quotient lies in [0.5, 2): without the integer bit, shift one
        // further and compensate the exponent.
        if (q[n+1]) begin
            mant = q[n:1];
            e    = e_base;
        end else begin
            mant = q[n-1:0];
            e    = e_base - ONE_E;
        end

        c   = '0;
        dbz = 1'b0;
        ovf = 1'b0;
        unf = 1'b0;
        if (zero_b) begin
            c   = {sign, {m{1'b1}}, {n{1'b0}}};
            dbz = 1'b1;
        end else if (zero_a) begin
            c = '0;
        end else if (e >= EMAX) begin
            c   = {sign, {m{1'b1}}, {n{1'b0}}};
            ovf = 1'b1;
        end else if (e <= ZERO_E) begin
            c   = '0;
            unf = 1'b1;
        end else begin
            c = {sign, e[m-1:0], mant};
        end
    end

endmodule

// File: rtl/fpdiv_32b_seq.sv
// Sequential single-precision divider c = a / b with valid/ready on both
// sides. Restoring mantissa division, one quotient bit per cycle; fixed
// latency of n+3 edges from accept to out_valid. Normals only, truncation.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (a_in, b_in)
//   out_valid, out_ready: result handshake (c_out, dbz, ovf, unf)
module fpdiv_32b_seq
    import fp_pkg::*;
#(
    parameter int unsigned m    = M,
    parameter int unsigned n    = N,
    parameter int unsigned BIAS = fp_pkg::BIAS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [m+n:0]   a_in,
    input  logic [m+n:0]   b_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [m+n:0]   c_out,
    output logic           dbz,
    output logic           ovf,
    output logic           unf
);

    localparam int unsigned CNT_W = $clog2(n + 2);

    state_t         state, state_nxt;
    fp_fields_t     fa, fb;

    logic           sign_r;
    logic [m-1:0]   ea_r, eb_r;
    logic           zero_a_r, zero_b_r;
    logic [n+1:0]   rem, div_b, q;
    logic [CNT_W-1:0] cnt;

    logic           q_bit;
    logic [n+1:0]   rem_diff;

    logic [m+n:0]   c_nrm;
    logic           dbz_nrm, ovf_nrm, unf_nrm;

    assign fa = fp_split(a_in);
    assign fb = fp_split(b_in);

    // One restoring step; rem_diff < div_b < 2^(n+1), so the shift fits.
    always_comb begin
        q_bit    = (rem >= div_b);
        rem_diff = q_bit ? (rem - div_b) : rem;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = DIV;
            end
            DIV:  if (cnt == '0) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            c_out <= '0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    sign_r   <= fa.sign ^ fb.sign;
                    ea_r     <= fa.exp;
                    eb_r     <= fb.exp;
                    zero_a_r <= (fa.exp == '0);
                    zero_b_r <= (fb.exp == '0);
                    rem      <= {2'b01, fa.mant};
                    div_b    <= {2'b01, fb.mant};
                    q        <= '0;
                    cnt      <= CNT_W'(n + 1);
                end
                DIV: begin
                    q   <= {q[n:0], q_bit};
                    rem <= {rem_diff[n:0], 1'b0};
                    cnt <= cnt - 1'b1;
                end
                NORM: begin
                    c_out <= c_nrm;
                    dbz   <= dbz_nrm;
                    ovf   <= ovf_nrm;
                    unf   <= unf_nrm;
                end
                default: ;
            endcase
        end
    end

    fpdiv_normalize #(
        .m    (m),
        .n    (n),
        .BIAS (BIAS)
    ) u_normalize (
        .sign   (sign_r),
        .ea     (ea_r),
        .eb     (eb_r),
        .q      (q),
        .zero_a (zero_a_r),
        .zero_b (zero_b_r),
        .c      (c_nrm),
        .dbz    (dbz_nrm),
        .ovf    (ovf_nrm),
        .unf    (unf_nrm)
    );

endmodule

// File: tb/tb_fpdiv_32b_seq.sv
// Self-checking bench for fpdiv_32b_seq: directed cases, backpressure,
// mid-operation reset and randomized operands against an arithmetic model.
module tb_fpdiv_32b_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in, b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c_out;
    logic        dbz, ovf, unf;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    typedef struct packed {
        logic [31:0] c;
        logic        dbz;
        logic        ovf;
        logic        unf;
    } res_t;

    always #5 clk = ~clk;

    fpdiv_32b_seq #(
        .m    (8),
        .n    (23),
        .BIAS (127)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .dbz       (dbz),
        .ovf       (ovf),
        .unf       (unf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value-level model: quotient of the 24-bit significands scaled by 2^24
    // and truncated, then normalised into [1, 2).
    function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        int          ea, eb, e;
        longint unsigned ma, mb, qv, mant;
        logic        s;
        logic [7:0]  e8;
        r  = '0;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        qv = (ma << 24) / mb;
        e  = ea - eb + 127;
        if (qv >= (64'd1 << 24)) begin
            mant = (qv >> 1) & 64'h7FFFFF;
        end else begin
            mant = qv & 64'h7FFFFF;
            e    = e - 1;
        end
        if (eb == 0) begin
            r.c   = {s, 8'hFF, 23'h0};
            r.dbz = 1'b1;
        end else if (ea == 0) begin
            r.c = 32'h0;
        end else if (e >= 255) begin
            r.c   = {s, 8'hFF, 23'h0};
            r.ovf = 1'b1;
        end else if (e <= 0) begin
            r.c   = 32'h0;
            r.unf = 1'b1;
        end else begin
            e8  = e[7:0];
            r.c = {s, e8, mant[22:0]};
        end
        return r;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int unsigned hold);
        res_t        r;
        int unsigned edges;
        bit          seen;
        r     = ref_div(a, b);
        edges = 0;
        seen  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        check("in_ready_before_op", 64'(in_ready), 64'd1);
        a_in      = a;
        b_in      = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("out_valid_seen", 64'(seen), 64'd1);
        check("latency", 64'(edges), 64'd26);
        check("c_out", 64'(c_out), 64'(r.c));
        check("flags", 64'({dbz, ovf, unf}), 64'({r.dbz, r.ovf, r.unf}));
        if (hold > 0) begin
            for (int i = 0; i < int'(hold); i++) begin
                @(negedge clk);
                in_valid = 1'b1;
                a_in     = $urandom;
                b_in     = $urandom;
                @(posedge clk);
                #1;
                check("hold_out_valid", 64'(out_valid), 64'd1);
                check("hold_in_ready", 64'(in_ready), 64'd0);
                check("hold_c_out", 64'(c_out), 64'(r.c));
                check("hold_flags", 64'({dbz, ovf, unf}), 64'({r.dbz, r.ovf, r.unf}));
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_c_out", 64'(c_out), 64'd0);
        check("rst_flags", 64'({dbz, ovf, unf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases; model expectations cross-checked with literals.
        check("ref_6_2", 64'(ref_div(32'h40C00000, 32'h40000000).c), 64'h40400000);
        check("ref_1_3", 64'(ref_div(32'h3F800000, 32'h40400000).c), 64'h3EAAAAAA);
        run_op(32'h40C00000, 32'h40000000, 0);
        run_op(32'h3F800000, 32'h40400000, 0);
        run_op(32'hBFC00000, 32'h3F000000, 0);
        run_op(32'h00000000, 32'h40000000, 0);
        run_op(32'h3F800000, 32'h80000000, 0);
        run_op(32'h00000000, 32'h00000000, 0);
        run_op(32'h7F000000, 32'h00800000, 0);
        run_op(32'h00800000, 32'h7F000000, 0);
        run_op(32'h40C00000, 32'h40000000, 10);
        run_op(32'h3F800000, 32'h40400000, 0);

        // Reset in the middle of the iteration.
        @(negedge clk);
        a_in     = 32'h3F800000;
        b_in     = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_c_out", 64'(c_out), 64'd0);
        check("midrst_flags", 64'({dbz, ovf, unf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h40C00000, 32'h40000000, 0);

        // Randomized operands, biased to reach zero / overflow / underflow.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra[30:23] = 8'h00;
                1: rb[30:23] = 8'h00;
                2: begin ra[30:23] = 8'(200 + $urandom_range(0, 55)); rb[30:23] = 8'(1 + $urandom_range(0, 20)); end
                3: begin ra[30:23] = 8'(1 + $urandom_range(0, 20)); rb[30:23] = 8'(100 + $urandom_range(0, 155)); end
                default: begin
                    ra[30:23] = 8'(90 + $urandom_range(0, 70));
                    rb[30:23] = 8'(90 + $urandom_range(0, 70));
                end
            endcase
            run_op(ra, rb, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
